// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory access unit.
// Store/load types, FSM states and byte-enable constants.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_SW  = 2'b00,
        ST_SH  = 2'b01,
        ST_SB  = 2'b10,
        ST_RSV = 2'b11
    } store_t;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LB  = 3'b001,
        LD_LBU = 3'b010,
        LD_LH  = 3'b011,
        LD_LHU = 3'b100
    } load_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUS  = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_B0   = 4'b0001;

    function automatic logic misaligned(
        input logic       we,
        input store_t     st,
        input load_t      ld,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        if (we) begin
            unique case (st)
                ST_SH:   m = lo[0];
                ST_SB:   m = 1'b0;
                default: m = (lo != 2'b00);
            endcase
        end else begin
            unique case (ld)
                LD_LH, LD_LHU: m = lo[0];
                LD_LB, LD_LBU: m = 1'b0;
                default:       m = (lo != 2'b00);
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte enables, write replication, load extension.
// Purely combinational; little-endian lane k = bits [8k+7:8k].
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  store_t      st,
    input  load_t       ld,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    always_comb begin
        bsel = rdata[7:0];
        unique case (1'b1)
            addr_lo == 2'd1: bsel = rdata[15:8];
            addr_lo == 2'd2: bsel = rdata[23:16];
            addr_lo == 2'd3: bsel = rdata[31:24];
            default:         bsel = rdata[7:0];
        endcase
        hsel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be        = BE_WORD;
        wdata_rep = wdata;
        if (we) begin
            unique case (st)
                ST_SH: begin
                    be        = addr_lo[1] ? BE_HI : BE_LO;
                    wdata_rep = {2{wdata[15:0]}};
                end
                ST_SB: begin
                    be        = BE_B0 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                default: begin
                    be        = BE_WORD;
                    wdata_rep = wdata;
                end
            endcase
        end
    end

    always_comb begin
        rdata_ext = rdata;
        unique case (ld)
            LD_LB:   rdata_ext = {{24{bsel[7]}}, bsel};
            LD_LBU:  rdata_ext = {24'h0, bsel};
            LD_LH:   rdata_ext = {{16{hsel[15]}}, hsel};
            LD_LHU:  rdata_ext = {16'h0, hsel};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store responder on a req/ack word bus.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [1:0]        store_type,
    input  logic [2:0]        load_type,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TMAX =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    store_t            st_q;
    load_t             ld_q;
    logic              we_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              finish;
    logic              fail;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              in_bus;

    mem_lane_align u_align (
        .addr_lo   (addr_q[1:0]),
        .we        (we_q),
        .st        (st_q),
        .ld        (ld_q),
        .wdata     (wdata_q),
        .rdata     (bus_rdata),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        finish  = 1'b0;
        fail    = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_rd | cpu_wr) begin
                    accept  = 1'b1;
                    state_n = BUS;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned(cpu_wr, store_t'(store_type),
                                   load_t'(load_type), cpu_addr[1:0])) begin
                        state_n = RESP;
                        finish  = 1'b1;
                        fail    = 1'b1;
                    end
`endif
                end
            end
            BUS: begin
                if (bus_ack) begin
                    state_n = RESP;
                    finish  = 1'b1;
                    cnt_n   = '0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (cnt == TMAX) begin
                        state_n = RESP;
                        finish  = 1'b1;
                        fail    = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            st_q    <= ST_SW;
            ld_q    <= LD_LW;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                st_q    <= store_t'(store_type);
                ld_q    <= load_t'(load_type);
                we_q    <= cpu_wr;
            end
            if (finish) begin
                err_q   <= fail;
                rdata_q <= (fail || we_q) ? '0 : rdata_ext;
            end
        end
    end

    assign in_bus    = (state == BUS);
    assign bus_req   = in_bus;
    assign bus_we    = in_bus & we_q;
    assign bus_addr  = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus_be    = in_bus ? be : 4'b0000;
    assign bus_wdata = (in_bus && we_q) ? wdata_rep : '0;
    assign cpu_stall = in_bus;
    assign cpu_done  = (state == RESP);
    assign cpu_err   = (state == RESP) & err_q;
    assign cpu_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit.
// Expected transactions are queued at drive time, popped at cpu_done.
module tb_mem_access_unit;

    typedef struct packed {
        logic        bus;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [1:0]  store_type;
    logic [2:0]  load_type;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_stall, cpu_err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .store_type (store_type),
        .load_type  (load_type),
        .cpu_rdata  (cpu_rdata),
        .cpu_done   (cpu_done),
        .cpu_stall  (cpu_stall),
        .cpu_err    (cpu_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic exp_t mk(input logic bus, we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic [31:0] rd, input logic err,
                                input logic chk_rd);
        exp_t e;
        e = '{bus: bus, we: we, addr: addr, be: be, wdata: wd,
              rdata: rd, err: err, chk_rd: chk_rd};
        return e;
    endfunction

    // ack_dly < 0 means never ack, relying on the timeout
    task automatic run(input string nm, input logic rd, wr,
                       input logic [31:0] addr, wd,
                       input logic [1:0] st, input logic [2:0] ld,
                       input logic [31:0] rdat, input int ack_dly,
                       input exp_t e);
        exp_t x;
        int   n;
        sb.push_back(e);
        @(negedge clk);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
        store_type = st; load_type = ld;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge clk);
        x = sb[0];
        chk({nm, ".req"}, {31'h0, bus_req}, {31'h0, x.bus});
        if (x.bus) begin
            chk({nm, ".we"}, {31'h0, bus_we}, {31'h0, x.we});
            chk({nm, ".addr"}, bus_addr, x.addr);
            chk({nm, ".be"}, {28'h0, bus_be}, {28'h0, x.be});
            if (x.we) chk({nm, ".wdata"}, bus_wdata, x.wdata);
            chk({nm, ".stall"}, {31'h0, cpu_stall}, 32'h1);
            if (ack_dly < 0) begin
                n = 0;
                while (bus_req && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                chk({nm, ".tmo_cycles"}, n, 32'd16);
            end else begin
                repeat (ack_dly) @(negedge clk);
                chk({nm, ".hold_req"}, {31'h0, bus_req}, 32'h1);
                chk({nm, ".hold_addr"}, bus_addr, x.addr);
                bus_ack = 1'b1; bus_rdata = rdat;
                @(negedge clk);
                bus_ack = 1'b0; bus_rdata = 32'h0;
            end
        end
        n = 0;
        while (!cpu_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({nm, ".done"}, {31'h0, cpu_done}, 32'h1);
        x = sb.pop_front();
        chk({nm, ".err"}, {31'h0, cpu_err}, {31'h0, x.err});
        if (x.chk_rd) chk({nm, ".rdata"}, cpu_rdata, x.rdata);
        chk({nm, ".resp_req"}, {31'h0, bus_req}, 32'h0);
        chk({nm, ".resp_stall"}, {31'h0, cpu_stall}, 32'h0);
        @(negedge clk);
        chk({nm, ".pulse"}, {31'h0, cpu_done}, 32'h0);
        chk({nm, ".idle_rdata"}, cpu_rdata, 32'h0);
    endtask

    initial begin
        reset = 1'b0;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        store_type = 0; load_type = 0; bus_ack = 0; bus_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst.req", {31'h0, bus_req}, 32'h0);
        chk("rst.done", {31'h0, cpu_done}, 32'h0);
        chk("rst.stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst.rdata", cpu_rdata, 32'h0);
        chk("rst.be", {28'h0, bus_be}, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        run("sb3", 0, 1, 32'h1003, 32'h0000_00A5, 2'b10, 3'b000, 0, 2,
            mk(1, 1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 0, 0, 0));
        run("sb1", 0, 1, 32'h1001, 32'h0000_003C, 2'b10, 3'b000, 0, 0,
            mk(1, 1, 32'h1000, 4'b0010, 32'h3C3C_3C3C, 0, 0, 0));
        run("lb", 1, 0, 32'h2001, 0, 2'b00, 3'b001, 32'h1234_80FF, 1,
            mk(1, 0, 32'h2000, 4'b1111, 0, 32'hFFFF_FF80, 0, 1));
        run("lbu", 1, 0, 32'h2001, 0, 2'b00, 3'b010, 32'h1234_80FF, 0,
            mk(1, 0, 32'h2000, 4'b1111, 0, 32'h0000_0080, 0, 1));
        run("lh", 1, 0, 32'h2002, 0, 2'b00, 3'b011, 32'h8001_0000, 3,
            mk(1, 0, 32'h2000, 4'b1111, 0, 32'hFFFF_8001, 0, 1));
        run("lhu", 1, 0, 32'h2002, 0, 2'b00, 3'b100, 32'h8001_0000, 0,
            mk(1, 0, 32'h2000, 4'b1111, 0, 32'h0000_8001, 0, 1));
        run("lb0", 1, 0, 32'h2000, 0, 2'b00, 3'b001, 32'h1234_567F, 0,
            mk(1, 0, 32'h2000, 4'b1111, 0, 32'h0000_007F, 0, 1));
        run("sh", 0, 1, 32'h2002, 32'h1111_BEEF, 2'b01, 3'b000, 0, 1,
            mk(1, 1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0));
        run("sh0", 0, 1, 32'h2000, 32'h0000_1234, 2'b01, 3'b000, 0, 0,
            mk(1, 1, 32'h2000, 4'b0011, 32'h1234_1234, 0, 0, 0));
        run("both", 1, 1, 32'h10, 32'hDEAD_BEEF, 2'b00, 3'b001, 0, 1,
            mk(1, 1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0));
        run("st11", 0, 1, 32'h20, 32'hCAFE_0001, 2'b11, 3'b000, 0, 0,
            mk(1, 1, 32'h20, 4'b1111, 32'hCAFE_0001, 0, 0, 0));
        run("ld111", 1, 0, 32'h30, 0, 2'b00, 3'b111, 32'h8765_4321, 0,
            mk(1, 0, 32'h30, 4'b1111, 0, 32'h8765_4321, 0, 1));
        run("tmo", 1, 0, 32'h40, 0, 2'b00, 3'b000, 0, -1,
            mk(1, 0, 32'h40, 4'b1111, 0, 32'h0, 1, 1));

        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = 32'h0;
        chk("late_ack.done", {31'h0, cpu_done}, 32'h0);
        chk("late_ack.stall", {31'h0, cpu_stall}, 32'h0);

`ifdef MEM_MISALIGN_TRAP_EN
        run("lw_mis", 1, 0, 32'h3, 0, 2'b00, 3'b000, 0, 0,
            mk(0, 0, 32'h0, 4'b0000, 0, 32'h0, 1, 1));
        run("sh_mis", 0, 1, 32'h5, 32'h1, 2'b01, 3'b000, 0, 0,
            mk(0, 1, 32'h0, 4'b0000, 0, 32'h0, 1, 1));
`else
        run("lw_mis", 1, 0, 32'h3, 0, 2'b00, 3'b000, 32'h0BAD_F00D, 0,
            mk(1, 0, 32'h0, 4'b1111, 0, 32'h0BAD_F00D, 0, 1));
`endif

        @(negedge clk);
        cpu_rd = 1'b1; cpu_addr = 32'h50; load_type = 3'b000;
        @(posedge clk);
        #1;
        cpu_rd = 1'b0;
        @(negedge clk);
        chk("rst_mid.req_before", {31'h0, bus_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_mid.req", {31'h0, bus_req}, 32'h0);
        chk("rst_mid.stall", {31'h0, cpu_stall}, 32'h0);
        chk("rst_mid.done", {31'h0, cpu_done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus_ack = 1'b0;
        chk("rst_mid.idle_req", {31'h0, bus_req}, 32'h0);
        chk("rst_mid.idle_done", {31'h0, cpu_done}, 32'h0);

        run("post_rst", 1, 0, 32'h60, 0, 2'b00, 3'b100, 32'h0000_ABCD, 0,
            mk(1, 0, 32'h60, 4'b1111, 0, 32'h0000_ABCD, 0, 1));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side responder for the multicycle CPU's load/store requests.
- Accepts a sub-word-typed request (address, store data, store/load type) and issues one word-wide transaction on a req/ack system bus.
- Generates byte enables and lane-replicated write data; extracts and sign- or zero-extends load data.
- Holds the CPU stalled until the transaction completes. Sits between the CPU datapath and the SoC bus/RAM.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in BUS awaiting bus_ack before error; 0 = no timeout.
- ADDR_W, 32: address width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_rd  input  1  load request.
- cpu_wr  input  1  store request.
- cpu_addr  input  ADDR_W  byte address.
- cpu_wdata  input  32  store data, right-aligned.
- store_type  input  2  word/half/byte store.
- load_type  input  3  word/byte/byteU/half/halfU load.
- cpu_rdata  output  32  extended load data, valid while cpu_done=1.
- cpu_done  output  1  one-cycle completion pulse.
- cpu_stall  output  1  request in flight.
- cpu_err  output  1  error qualifier, valid with cpu_done.
- bus_req  output  1  bus request, held until ack.
- bus_we  output  1  write strobe.
- bus_addr  output  ADDR_W  word-aligned address, bits [1:0]=0.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated write data.
- bus_ack  input  1  bus completion; sampled only in BUS.
- bus_rdata  input  32  read data, valid with bus_ack.

Behaviour:
- Reset (reset=0): state IDLE. All outputs 0. Timeout counter 0. Any in-flight transaction is abandoned immediately; bus_req falls asynchronously.
- Encodings:
  - Store: SW=2'b00, SH=2'b01, SB=2'b10; 2'b11 is treated as SW.
  - Load: LW=3'b000, LB=3'b001, LBU=3'b010, LH=3'b011, LHU=3'b100; other values are treated as LW.
- Byte order is little-endian: lane k = bits [8k+7:8k].
- IDLE: on a clk edge with cpu_rd|cpu_wr=1, register addr, wdata and type, then go to BUS.
  - cpu_wr has priority when both are high; the access is a write.
  - cpu_stall=1 from the following cycle.
- BUS: bus_req=1 and all bus outputs are stable until bus_ack is sampled high.
  - On ack: capture the extracted load data, go to RESP, drop bus_req.
  - An ack in the same cycle bus_req first rises is legal; minimum latency is 3 cycles from request to cpu_done.
- RESP: cpu_done=1 for one cycle, cpu_stall=0, then go to IDLE.
  - A new request is accepted on the edge that leaves RESP only after returning to IDLE; requests present during RESP are ignored.
- Write lanes:
  - SW: be=4'b1111, wdata=cpu_wdata.
  - SH: be=4'b0011 if addr[1]=0, else 4'b1100; wdata={2{wdata[15:0]}}.
  - SB: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
- Reads: bus_be=4'b1111, bus_we=0.
- Load extraction:
  - Select the byte by addr[1:0], or the halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Timeout: the counter increments each BUS cycle without ack.
  - On reaching TIMEOUT_CYCLES: drop bus_req, go to RESP with cpu_err=1 and cpu_rdata=0.
  - The counter clears on leaving BUS.
- bus_ack outside BUS is ignored. cpu_rdata holds 0 except during RESP.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned requests (half with addr[0]=1; word with addr[1:0]!=0) generate no bus cycle.
  - Path is IDLE->RESP directly, with cpu_err=1 and cpu_rdata=0.
- Undefined: the offending low address bits are ignored (truncated); no error is raised.

Decomposition:
- Package mem_access_pkg holds:
  - store/load type encodings;
  - state enum {IDLE, BUS, RESP};
  - byte-enable constants.
- Sub-module mem_lane_align (combinational): inputs addr[1:0], types, wdata and bus_rdata; outputs be, replicated wdata and extended rdata. The FSM stays in the top module.

Test Plan:
- SB, addr=0x1003, wdata=0x000000A5, ack after 2 cycles -> bus_addr=0x1000, be=4'b1000, bus_wdata=0xA5A5A5A5, we=1, cpu_done after ack, err=0.
- LB, addr=0x2001, bus_rdata=0x1234_80FF -> cpu_rdata=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LH, addr=0x2002, rdata=0x8001_0000 -> 0xFFFF8001. LHU -> 0x00008001. SH at addr 0x2002 -> be=4'b1100.
- cpu_rd and cpu_wr both high, SW, addr=0x10 -> single write, be=4'b1111, no read cycle.
- No ack, TIMEOUT_CYCLES=16 -> bus_req drops after 16 BUS cycles, cpu_done=1, cpu_err=1, rdata=0. A later ack is ignored.
- reset pulsed low mid-BUS -> bus_req=0 immediately, state IDLE, stall=0. With MEM_MISALIGN_TRAP_EN, LW at addr 0x3 -> no bus_req, cpu_err=1.
